half_adder: RTL and testbench

// - Registered bank of WIDTH independent 1-bit half adders: sum = a ^ b, carry = a & b per lane.
// - Basic arithmetic leaf cell; feeds full-adder chains and carry-save trees in datapath blocks.
// - Optional carry-event counter for datapath debug and coverage.

---
 rtl/half_adder_pkg.sv | 21 ++
 rtl/half_adder_ha_cell.sv | 18 +
 rtl/half_adder.sv | 69 ++++++
 tb/tb_half_adder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared types and defaults for the half_adder lane bank.
// Optional carry-event counter is enabled by HALF_ADDER_STATS_EN.
package half_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned DEFAULT_CNT_W = 16;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_lane_t;

    // Combine two operand bits into one lane result.
    function automatic ha_lane_t ha_eval(input logic a, input logic b);
        ha_lane_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_ha_cell.sv
// Combinational 1-bit half adder leaf cell.
// Instantiated per lane by half_adder (see HALF_ADDER_STATS_EN there).
module ha_cell
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    ha_lane_t lane_c;

    assign lane_c = ha_eval(a, b);
    assign sum    = lane_c.sum;
    assign carry  = lane_c.carry;

endmodule

// File: rtl/half_adder.sv
// Registered bank of WIDTH independent half adders with 1-cycle latency.
// Define HALF_ADDER_STATS_EN to build the saturating carry-event counter.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             carry_any,
    output logic [CNT_W-1:0] carry_cnt
);

    ha_lane_t         lane_c [WIDTH];
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;

    // One independent cell per lane; nothing crosses lane boundaries.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (lane_c[i].sum),
            .carry (lane_c[i].carry)
        );
        assign sum_c[i]   = lane_c[i].sum;
        assign carry_c[i] = lane_c[i].carry;
    end

    // Result registers load only on accepted input, so X on idle operands is never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= '0;
            carry_any <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum       <= sum_c;
                carry     <= carry_c;
                carry_any <= |carry_c;
            end
        end
    end

`ifdef HALF_ADDER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating count of accepted inputs that produced any carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (in_valid && (|carry_c) && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end
`else
    assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: WIDTH=1 and WIDTH=4 (CNT_W=2) instances vs a lane-arithmetic model.
// Expected carry_cnt follows HALF_ADDER_STATS_EN when the bench is built.
module tb_half_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       a1, b1;
    logic [3:0] a4, b4;

    logic        ov1, s1, c1, any1;
    logic [15:0] cnt1;
    logic        ov4, any4;
    logic [3:0]  s4, c4;
    logic [1:0]  cnt4;

    int n_tests;
    int n_fail;

    // Model state: what each DUT should show after the most recent edge.
    int ev1, es1, ec1, eany1, ecnt1;
    int ev4, es4, ec4, eany4, ecnt4;

    half_adder #(.WIDTH(1), .CNT_W(16)) dut_w1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .out_valid (ov1),
        .sum       (s1),
        .carry     (c1),
        .carry_any (any1),
        .carry_cnt (cnt1)
    );

    half_adder #(.WIDTH(4), .CNT_W(2)) dut_w4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a4),
        .b         (b4),
        .out_valid (ov4),
        .sum       (s4),
        .carry     (c4),
        .carry_any (any4),
        .carry_cnt (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Each lane adds its two bits as integers: bit0 of the total is sum, bit1 is carry.
    function automatic void add_lanes(input logic [3:0] av, input logic [3:0] bv, input int w,
                                      output int s, output int c);
        s = 0;
        c = 0;
        for (int i = 0; i < w; i++) begin
            int t;
            t = int'(av[i]) + int'(bv[i]);
            s += (t % 2) << i;
            c += (t / 2) << i;
        end
    endfunction

    task automatic model_update();
        int s, c;
        if (rst) begin
            ev1 = 0; es1 = 0; ec1 = 0; eany1 = 0; ecnt1 = 0;
            ev4 = 0; es4 = 0; ec4 = 0; eany4 = 0; ecnt4 = 0;
        end else begin
            ev1 = int'(in_valid);
            ev4 = int'(in_valid);
            if (in_valid) begin
                add_lanes({3'b000, a1}, {3'b000, b1}, 1, s, c);
                es1 = s; ec1 = c; eany1 = (c != 0) ? 1 : 0;
                if (eany1 == 1 && ecnt1 < 65535) ecnt1++;
                add_lanes(a4, b4, 4, s, c);
                es4 = s; ec4 = c; eany4 = (c != 0) ? 1 : 0;
                if (eany4 == 1 && ecnt4 < 3) ecnt4++;
            end
        end
    endtask

    task automatic check_all();
        int xc1, xc4;
`ifdef HALF_ADDER_STATS_EN
        xc1 = ecnt1;
        xc4 = ecnt4;
`else
        xc1 = 0;
        xc4 = 0;
`endif
        check_eq("w1_out_valid", 16'(ov1),  16'(ev1));
        check_eq("w1_sum",       16'(s1),   16'(es1));
        check_eq("w1_carry",     16'(c1),   16'(ec1));
        check_eq("w1_carry_any", 16'(any1), 16'(eany1));
        check_eq("w1_carry_cnt", cnt1,      16'(xc1));
        check_eq("w4_out_valid", 16'(ov4),  16'(ev4));
        check_eq("w4_sum",       16'(s4),   16'(es4));
        check_eq("w4_carry",     16'(c4),   16'(ec4));
        check_eq("w4_carry_any", 16'(any4), 16'(eany4));
        check_eq("w4_carry_cnt", 16'(cnt4), 16'(xc4));
        check_eq("w4_sum_and_carry_disjoint", 16'(s4 & c4), 16'h0000);
    endtask

    // Drive one cycle of inputs, advance an edge, update the model and compare off-edge.
    task automatic step(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv);
        rst      = r;
        in_valid = v;
        a4       = av;
        b4       = bv;
        a1       = av[0];
        b1       = bv[0];
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic       rr, rv;

        n_tests = 0;
        n_fail  = 0;
        ev1 = 0; es1 = 0; ec1 = 0; eany1 = 0; ecnt1 = 0;
        ev4 = 0; es4 = 0; ec4 = 0; eany4 = 0; ecnt4 = 0;
        rst = 1'b1; in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;

        // Reset overrides a valid 11 input.
        step(1'b1, 1'b1, 4'hF, 4'hF);
        step(1'b1, 1'b1, 4'hF, 4'hF);
        check_eq("reset_carry_lit", 16'(c4), 16'h0000);

        // Truth table on consecutive cycles.
        step(1'b0, 1'b1, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'hF);
        step(1'b0, 1'b1, 4'hF, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        check_eq("tt11_sum_lit",   16'(s1), 16'h0000);
        check_eq("tt11_carry_lit", 16'(c1), 16'h0001);

        // Hold with known and with unknown operands while idle.
        step(1'b0, 1'b0, 4'h0, 4'h0);
        check_eq("hold_carry_lit", 16'(c1), 16'h0001);
        step(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);

        // Independent lanes.
        step(1'b0, 1'b1, 4'b1100, 4'b1010);
        check_eq("w4_vec_sum_lit",   16'(s4), 16'h0006);
        check_eq("w4_vec_carry_lit", 16'(c4), 16'h0008);

        // Counter saturation on the CNT_W=2 instance, then a no-carry input.
        step(1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'hF, 4'hF);
        step(1'b0, 1'b1, 4'h0, 4'hF);

        // Reset right after a valid 11.
        step(1'b0, 1'b1, 4'hF, 4'hF);
        step(1'b1, 1'b1, 4'hF, 4'hF);
        check_eq("midreset_valid_lit", 16'(ov4), 16'h0000);

        // Random traffic with occasional reset and X on idle cycles.
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rr = ($urandom_range(0, 19) == 0);
            rv = ($urandom_range(0, 3) != 0);
            if (!rv && $urandom_range(0, 1) == 1) begin
                ra = 4'bxxxx;
                rb = 4'bxxxx;
            end
            step(rr, rv, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
